// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: datapath widths and load funct3 encodings.
package wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load data alignment and sign/zero extension, with illegal/misaligned detection.
module load_extend
  import wb_pkg::*;
(
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [XLEN-1:0] shifted;

  assign shifted = ld_rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (ld_funct3)
      F3_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU: data = {24'd0, shifted[7:0]};
      F3_LH: begin
        data = {{16{shifted[15]}}, shifted[15:0]};
        err  = ld_addr_lo[0];
      end
      F3_LHU: begin
        data = {16'd0, shifted[15:0]};
        err  = ld_addr_lo[0];
      end
      F3_LW: begin
        // Only legal when aligned, so the shift is a no-op on the written path.
        data = shifted;
        err  = (ld_addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU results and load responses onto the single register-file
// write port, and tracks in-flight loads per destination for issue-stage stall decisions.
module writeback_unit
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_addr_lo,
  input  logic [XLEN-1:0]       ld_rdata,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [XLEN-1:0]       write_data,
  output logic                  ld_err,
  input  logic                  err_clear,
  output logic [31:0]           retired_count
);

  logic [XLEN-1:0]       ext_data;
  logic                  ext_err;
  logic [REG_ADDR_W-1:0] res_rd;
  logic [XLEN-1:0]       res_data;
  logic                  res_commit;
  logic [31:0]           busy_q, busy_d;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] wreg_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  err_q;
  logic [31:0]           retired_q;

  load_extend u_load_extend (
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .ld_rdata   (ld_rdata),
    .data       (ext_data),
    .err        (ext_err)
  );

  // Loads cannot be back-pressured, so they always win the write port.
  assign alu_ready = !ld_valid;
  assign ld_ready  = 1'b1;

  always_comb begin
    res_rd     = ld_valid ? ld_rd : alu_rd;
    res_data   = ld_valid ? ext_data : alu_data;
    res_commit = ld_valid ? !ext_err : alu_valid;
  end

  always_comb begin
    busy_d = busy_q;
    if (ld_valid) busy_d[ld_rd] = 1'b0;
    if (ld_issue) busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= '0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      busy_q <= busy_d;
      we_q   <= res_commit && (res_rd != '0);
      if (res_commit) begin
        wreg_q    <= res_rd;
        wdata_q   <= res_data;
        retired_q <= retired_q + 32'd1;
      end
      if (ld_valid && ext_err) begin
        err_q <= 1'b1;
      end else if (err_clear) begin
        err_q <= 1'b0;
      end
    end
  end

  // The write in flight is not yet visible in the register file, so it still counts as busy.
  assign rs1_busy = busy_q[rs1_addr] | (we_q && (wreg_q == rs1_addr) && (rs1_addr != '0));
  assign rs2_busy = busy_q[rs2_addr] | (we_q && (wreg_q == rs2_addr) && (rs2_addr != '0));

  assign write_enable  = we_q;
  assign write_reg     = wreg_q;
  assign write_data    = wdata_q;
  assign ld_err        = err_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected writes are queued as stimulus is accepted
// and checked by a monitor when the write port fires.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rdata;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        ld_err;
  logic        err_clear;
  logic [31:0] retired_count;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_retired = 0;

  writeback_unit dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .ld_issue      (ld_issue),
    .ld_issue_rd   (ld_issue_rd),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_rd         (ld_rd),
    .ld_funct3     (ld_funct3),
    .ld_addr_lo    (ld_addr_lo),
    .ld_rdata      (ld_rdata),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .write_enable  (write_enable),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .ld_err        (ld_err),
    .err_clear     (err_clear),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Write-port monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && write_enable) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got reg=%0d data=%h, required no write",
                 write_reg, write_data);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        if (write_reg !== e.rd || write_data !== e.data) begin
          bad++;
          $display("FAIL write_port: got reg=%0d data=%h, required reg=%0d data=%h",
                   write_reg, write_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 3'b010; ld_addr_lo = 0; ld_rdata = 0;
    rs1_addr = 0; rs2_addr = 0; err_clear = 0;
  endtask

  task automatic push_write(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd = rd;
    e.data = data;
    exp_retired++;
    if (rd != 0) sb_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    rs1_addr = 7;
    #2;
    total++;
    if (write_enable !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_write_port: got we=%b reg=%0d data=%h, required 0/0/0",
               write_enable, write_reg, write_data);
    end
    total++;
    if (ld_err !== 1'b0 || retired_count !== 32'd0 || rs1_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got err=%b retired=%0d busy=%b, required 0/0/0",
               ld_err, retired_count, rs1_busy);
    end
    ld_valid = 1;
    #1;
    total++;
    if (alu_ready !== 1'b0 || ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got alu_ready=%b ld_ready=%b, required 0/1", alu_ready, ld_ready);
    end
    ld_valid = 0;
    @(negedge clk);
    reset = 1;
    cycle();
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234_5678; rs1_addr = 5;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++;
      $display("FAIL alu_ready_idle: got %b, required 1", alu_ready);
    end
    push_write(5, 32'h1234_5678);
    cycle();
    alu_rd = 0; alu_data = 32'hDEAD_BEEF;
    push_write(0, 32'hDEAD_BEEF);
    #1;
    total++;
    if (retired_count !== 32'd1 || rs1_busy !== 1'b1) begin
      bad++;
      $display("FAIL alu_first: got retired=%0d rs1_busy=%b, required 1/1", retired_count, rs1_busy);
    end
    cycle();
    alu_valid = 0;
    #1;
    total++;
    if (write_enable !== 1'b0 || retired_count !== exp_retired) begin
      bad++;
      $display("FAIL alu_x0: got we=%b retired=%0d, required 0/%0d",
               write_enable, retired_count, exp_retired);
    end
    cycle();
  endtask

  task automatic test_priority();
    ld_valid = 1; ld_rd = 9; ld_funct3 = 3'b010; ld_addr_lo = 0; ld_rdata = 32'hAABB_CCDD;
    alu_valid = 1; alu_rd = 10; alu_data = 32'h0000_1111;
    #1;
    total++;
    if (alu_ready !== 1'b0) begin
      bad++;
      $display("FAIL priority_stall: got alu_ready=%b, required 0", alu_ready);
    end
    push_write(9, 32'hAABB_CCDD);
    cycle();
    ld_valid = 0;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++;
      $display("FAIL priority_release: got alu_ready=%b, required 1", alu_ready);
    end
    push_write(10, 32'h0000_1111);
    cycle();
    alu_valid = 0;
    cycle();
    total++;
    if (retired_count !== exp_retired) begin
      bad++;
      $display("FAIL priority_retired: got %0d, required %0d", retired_count, exp_retired);
    end
  endtask

  task automatic test_back_to_back_extend();
    logic [2:0]  f3  [6];
    logic [1:0]  lo  [6];
    logic [31:0] raw [6];
    logic [31:0] exp [6];
    f3[0] = 3'b000; lo[0] = 3; raw[0] = 32'h80FF_0000; exp[0] = 32'hFFFF_FF80;
    f3[1] = 3'b101; lo[1] = 2; raw[1] = 32'h80FF_0000; exp[1] = 32'h0000_80FF;
    f3[2] = 3'b010; lo[2] = 0; raw[2] = 32'h80FF_0000; exp[2] = 32'h80FF_0000;
    f3[3] = 3'b100; lo[3] = 1; raw[3] = 32'h0000_8000; exp[3] = 32'h0000_0080;
    f3[4] = 3'b001; lo[4] = 0; raw[4] = 32'h0000_8001; exp[4] = 32'hFFFF_8001;
    f3[5] = 3'b000; lo[5] = 0; raw[5] = 32'h0000_007F; exp[5] = 32'h0000_007F;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1; ld_rd = 5'(11 + i); ld_funct3 = f3[i]; ld_addr_lo = lo[i]; ld_rdata = raw[i];
      push_write(5'(11 + i), exp[i]);
      cycle();
    end
    ld_valid = 0;
    cycle();
    total++;
    if (retired_count !== exp_retired || ld_err !== 1'b0) begin
      bad++;
      $display("FAIL extend_retired: got retired=%0d err=%b, required %0d/0",
               retired_count, ld_err, exp_retired);
    end
  endtask

  task automatic test_scoreboard();
    rs1_addr = 7; rs2_addr = 0;
    ld_issue = 1; ld_issue_rd = 0;
    cycle();
    total++;
    if (rs2_busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_x0: got %b, required 0", rs2_busy);
    end
    ld_issue_rd = 7;
    cycle();
    ld_issue = 0;
    #1;
    total++;
    if (rs1_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_issue: got %b, required 1", rs1_busy);
    end
    ld_valid = 1; ld_rd = 7; ld_funct3 = 3'b010; ld_addr_lo = 0; ld_rdata = 32'h0707_0707;
    #1;
    total++;
    if (rs1_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_response_cycle: got %b, required 1", rs1_busy);
    end
    push_write(7, 32'h0707_0707);
    cycle();
    ld_valid = 0;
    #1;
    total++;
    if (rs1_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_write_cycle: got %b, required 1", rs1_busy);
    end
    cycle();
    total++;
    if (rs1_busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_cleared: got %b, required 0", rs1_busy);
    end
    // Set and clear of the same register in one cycle: the set must survive.
    rs2_addr = 8;
    ld_issue = 1; ld_issue_rd = 8;
    cycle();
    ld_valid = 1; ld_rd = 8; ld_rdata = 32'h0808_0808;
    push_write(8, 32'h0808_0808);
    cycle();
    ld_valid = 0; ld_issue = 0;
    cycle();
    total++;
    if (rs2_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_set_wins: got %b, required 1", rs2_busy);
    end
    ld_valid = 1; ld_rd = 8; ld_rdata = 32'h0000_0808;
    push_write(8, 32'h0000_0808);
    cycle();
    ld_valid = 0;
    cycle();
    total++;
    if (rs2_busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_set_wins_cleared: got %b, required 0", rs2_busy);
    end
  endtask

  task automatic test_error();
    rs1_addr = 12;
    ld_issue = 1; ld_issue_rd = 12;
    cycle();
    ld_issue = 0;
    ld_valid = 1; ld_rd = 12; ld_funct3 = 3'b010; ld_addr_lo = 1; ld_rdata = 32'h1212_1212;
    cycle();
    ld_valid = 0;
    #1;
    total++;
    if (ld_err !== 1'b1 || write_enable !== 1'b0 || rs1_busy !== 1'b0) begin
      bad++;
      $display("FAIL err_misaligned_lw: got err=%b we=%b busy=%b, required 1/0/0",
               ld_err, write_enable, rs1_busy);
    end
    total++;
    if (retired_count !== exp_retired) begin
      bad++;
      $display("FAIL err_retired: got %0d, required %0d", retired_count, exp_retired);
    end
    err_clear = 1;
    cycle();
    err_clear = 0;
    #1;
    total++;
    if (ld_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: got %b, required 0", ld_err);
    end
    // A new error coinciding with err_clear keeps the flag set.
    ld_valid = 1; ld_rd = 13; ld_funct3 = 3'b011; ld_addr_lo = 0; err_clear = 1;
    cycle();
    ld_valid = 0; err_clear = 0;
    #1;
    total++;
    if (ld_err !== 1'b1) begin
      bad++;
      $display("FAIL err_new_wins: got %b, required 1", ld_err);
    end
    ld_valid = 1; ld_rd = 14; ld_funct3 = 3'b001; ld_addr_lo = 1; err_clear = 1;
    cycle();
    ld_valid = 0; err_clear = 0;
    cycle();
    total++;
    if (ld_err !== 1'b1 || retired_count !== exp_retired) begin
      bad++;
      $display("FAIL err_misaligned_lh: got err=%b retired=%0d, required 1/%0d",
               ld_err, retired_count, exp_retired);
    end
    err_clear = 1;
    cycle();
    err_clear = 0;
  endtask

  task automatic test_reset_mid();
    rs1_addr = 3; rs2_addr = 4;
    ld_issue = 1; ld_issue_rd = 3;
    cycle();
    ld_issue = 0;
    alu_valid = 1; alu_rd = 4; alu_data = 32'hCAFE_F00D;
    push_write(4, 32'hCAFE_F00D);
    cycle();
    alu_valid = 0;
    #1;
    total++;
    if (write_enable !== 1'b1 || rs1_busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_setup: got we=%b busy3=%b, required 1/1", write_enable, rs1_busy);
    end
    reset = 0;
    #1;
    sb_q.delete();
    exp_retired = 0;
    total++;
    if (write_enable !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_write: got we=%b reg=%0d data=%h, required 0/0/0",
               write_enable, write_reg, write_data);
    end
    total++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || retired_count !== 32'd0 || ld_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_state: got busy=%b%b retired=%0d err=%b, required 00/0/0",
               rs1_busy, rs2_busy, retired_count, ld_err);
    end
    @(negedge clk);
    reset = 1;
    cycle();
    total++;
    if (rs1_busy !== 1'b0 || write_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_after: got busy=%b we=%b, required 0/0", rs1_busy, write_enable);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_priority();
    test_back_to_back_extend();
    test_scoreboard();
    test_error();
    test_reset_mid();
    cycle();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL pending_writes: got %0d outstanding, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
